prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes it
// into instruction memory as 32-bit words while holding the CPU in reset.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        state_dbg
);

    // Byte handshake: a byte transfers on a rising edge where byte_valid and
    // byte_ready are both 1; byte_ready is registered and never looks at byte_valid.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [1:0]        idx;
    logic [23:0]       word_buf;
    logic [7:0]        csum;

    logic              accept;
    logic [15:0]       len_full;
    logic              len_bad;
    logic [ADDR_W:0]   wc_next;
    logic              last_word;

    assign accept    = byte_valid & byte_ready;
    assign len_full  = {byte_in, len_lo};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
    assign wc_next   = word_count + 1'b1;
    assign last_word = (16'(wc_next) == len);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            len_lo     <= '0;
            len        <= '0;
            idx        <= '0;
            word_buf   <= '0;
            csum       <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_LO;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        idx        <= '0;
                        csum       <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= byte_in;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len <= len_full;
                        if (len_bad) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum ^ byte_in;
                        idx  <= idx + 2'd1;
                        case (idx)
                            2'd0: word_buf[7:0]   <= byte_in;
                            2'd1: word_buf[15:8]  <= byte_in;
                            2'd2: word_buf[23:16] <= byte_in;
                            default: begin
                                // Fourth byte completes the word; write it next cycle.
                                state      <= WRITE;
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_din    <= {byte_in, word_buf};
                                mem_addr   <= word_count[ADDR_W-1:0];
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_count <= wc_next;
                    byte_ready <= 1'b1;
                    state      <= last_word ? CSUM : DATA;
                end
                CSUM: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        if (byte_in == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: transaction-level model of the byte stream,
// per-cycle write/latency checks and end-of-load status checks.
module tb_prog_loader;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;
    localparam int W         = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;
    logic [2:0]        state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  load_words[$];
    int acc_k = 0;
    int cur_n = 0;
    bit pending_we = 1'b0;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, err, word_count}, 64'd0);
    endtask

    // ---------------- model ----------------
    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            x ^= load_words[i][7:0] ^ load_words[i][15:8] ^ load_words[i][23:16] ^ load_words[i][31:24];
        return x;
    endfunction

    // Per-cycle compare: a write must appear exactly one cycle after each 4th data
    // byte of the stream is taken, and must match the next expected (addr, word).
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            pending_we = 1'b0;
        end else begin
            check("mem_we_timing", mem_we, pending_we);
            if (mem_we) begin
                check("ready_in_write", byte_ready, 1'b0);
                check("hold_in_write", cpu_hold, 1'b1);
                check("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e[W-1:32]);
                    check("write_data", mem_din, e[31:0]);
                end
            end
            check("done_err_exclusive", done & err, 1'b0);
            if (byte_valid && byte_ready) begin
                pending_we = (acc_k >= 2) && (acc_k < 2 + 4 * cur_n) && (((acc_k - 2) % 4) == 3);
                acc_k++;
            end else begin
                pending_we = 1'b0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  g;
        logic rdy;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        byte_valid = 1'b0;
        repeat (g) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        rdy        = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (!rdy) check("byte_accept_timeout", rdy, 1'b1);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    // One complete load of load_words[0..n-1]; expectations come from the model.
    task automatic run_load(input logic [15:0] n, input logic [7:0] csum_byte,
                            input int max_gap, input bit mid_start);
        bit bad_len;
        bit ok;
        int nn;
        logic [31:0] w;
        bad_len = (n == 16'd0) || (int'(n) > MAX_WORDS);
        nn      = bad_len ? 0 : int'(n);
        ok      = !bad_len && (csum_byte == model_csum(nn));
        acc_k   = 0;
        cur_n   = nn;
        for (int i = 0; i < nn; i++)
            exp_q.push_back({ADDR_W'(i), load_words[i]});
        pulse_start();
        check("start_ready", byte_ready, 1'b1);
        check("start_hold", cpu_hold, 1'b1);
        check("start_clear", {done, err, word_count}, 64'd0);
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
        if (!bad_len) begin
            if (mid_start) pulse_start();
            for (int i = 0; i < nn; i++) begin
                w = load_words[i];
                for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], max_gap);
            end
            send_byte(csum_byte, max_gap);
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done || err) break;
        end
        check("end_done", done, ok);
        check("end_err", err, !ok);
        check("end_word_count", word_count, nn);
        check("end_hold", cpu_hold, !ok);
        check("end_ready", byte_ready, 1'b0);
        check("end_queue_empty", exp_q.size(), 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        #2 rst = 1'b1;
        tick();
        check_all_zero("idle_after_reset");

        // Two-word load; XOR of 13 00 00 00 78 56 34 12 is 1B
        load_words = '{32'h0000_0013, 32'h1234_5678};
        check("pin_csum_two_words", model_csum(2), 8'h1B);
        run_load(16'd2, 8'h1B, 0, 1'b0);
        check("lit_wc_2", word_count, 2);
        check("lit_done_2", done, 1'b1);
        check("lit_hold_2", cpu_hold, 1'b0);
        // Same stream with checksum 7B is a mismatch
        run_load(16'd2, 8'h7B, 0, 1'b0);
        check("lit_err_7b", err, 1'b1);

        // Zero length
        load_words = {};
        run_load(16'd0, 8'h00, 0, 1'b0);
        repeat (3) tick();
        check("lit_len0_err", err, 1'b1);
        check("lit_len0_hold", cpu_hold, 1'b1);
        check("lit_len0_ready", byte_ready, 1'b0);

        // Length one past the maximum
        run_load(16'h0401, 8'h00, 0, 1'b0);
        check("lit_len1025_err", err, 1'b1);

        // Single word AA BB CC DD: checksum 00 good, 01 bad
        load_words = '{32'hDDCC_BBAA};
        check("pin_csum_one_word", model_csum(1), 8'h00);
        run_load(16'd1, 8'h00, 0, 1'b0);
        check("lit_n1_done", done, 1'b1);
        run_load(16'd1, 8'h01, 0, 1'b0);
        check("lit_n1_err", err, 1'b1);
        check("lit_n1_wc", word_count, 1);

        // Same two-word load with random valid gaps
        load_words = '{32'h0000_0013, 32'h1234_5678};
        run_load(16'd2, 8'h1B, 5, 1'b0);

        // Random loads, some with bad checksum and an ignored mid-load start
        for (int r = 0; r < 20; r++) begin
            int n;
            logic [7:0] cs;
            n = $urandom_range(6, 1);
            load_words = {};
            for (int i = 0; i < n; i++) load_words.push_back($urandom);
            cs = model_csum(n);
            if ($urandom_range(3, 0) == 0) cs ^= 8'($urandom_range(255, 1));
            run_load(16'(n), cs, 5, 1'($urandom_range(1, 0)));
        end

        // Maximum length: last word must land at address MAX_WORDS-1
        load_words = {};
        for (int i = 0; i < MAX_WORDS; i++) load_words.push_back($urandom);
        run_load(16'(MAX_WORDS), model_csum(MAX_WORDS), 0, 1'b0);

        // Reset mid-load after 6 data bytes of an N=4 load
        load_words = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        acc_k = 0;
        cur_n = 4;
        exp_q.push_back({ADDR_W'(0), load_words[0]});
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        check("reset_queue_empty", exp_q.size(), 0);
        exp_q = {};
        #12 rst = 1'b1;
        repeat (3) begin
            tick();
            check_all_zero("idle_until_start");
        end
        load_words = '{32'hCAFE_F00D};
        run_load(16'd1, model_csum(1), 2, 1'b0);
        check("lit_after_reset_done", done, 1'b1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
